serial_add_ctrl: RTL

Bit-serial adder controller that sequences a single half-adder-based full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands. Operands are latched on a Start request. The block shifts one bit pair per cycle through the shared adder cell and holds the registered carry between cycles. Sum and Cout are presented with a one-cycle Done pulse. It is the area-minimal alternative to the ripple adder chain and is the first sequential consumer of the HA primitive.

---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_fa_cell.sv | 31 +++
 rtl/serial_add_ctrl_ha.sv | 13 +
 rtl/serial_add_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// State encodings are fixed so traces stay readable across revisions.
package serial_add_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Full-adder cell built from two half adders.
// Purely combinational; shared by every bit position over time.
module serial_add_ctrl_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  serial_add_ctrl_ha u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  serial_add_ctrl_ha u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl_ha.sv
// Half-adder primitive.
// Combinational sum and carry of two bits.
module serial_add_ctrl_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walked over WIDTH cycles.
// Result and carry-out are published with a one-cycle Done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  state_t          nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;
  logic [WIDTH-1:0] sr_nxt;

  serial_add_ctrl_fa_cell u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c),
    .s  (s),
    .co (co)
  );

  assign sr_nxt = {s, sr[WIDTH-1:1]};
  assign Busy   = (state != IDLE);
  assign Done   = (state == DONE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (Start) nxt = RUN;
      RUN:     if (cnt == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            sa  <= A;
            sb  <= B;
            c   <= Cin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_nxt;
          c   <= co;
          cnt <= cnt + 1'b1;
          // Final bit: publish the result including this cycle's sum bit
          if (cnt == LAST) begin
            Sum  <= sr_nxt;
            Cout <= co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
